// File: rtl/pprm_inv_sbox_pipe.sv
// rtl/pprm_inv_sbox_pipe.sv - pipelined AES inverse S-box, three-stage composite-field inverter
//
// Purpose: out_data = InvSBox(in_data). The inverse affine transform is followed by
//   a GF((2^4)^2) inverter split over three registered stages behind an elastic
//   valid/ready handshake (capacity 3, one byte per cycle, no bubbles).
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   in_data is valid
//   in_ready   block accepts in_data this cycle (combinational on out_ready)
//   in_data    ciphertext-side byte
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data this cycle
//   out_data   InvSBox(in_data)
//   busy       any pipeline stage holds a valid byte
//   out_parity ^out_data, registered with out_data (only with PPRM_INV_PARITY_EN)
// Optional feature macro: PPRM_INV_PARITY_EN

module pprm_inv_sbox_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
`ifdef PPRM_INV_PARITY_EN
  ,
  output logic       out_parity
`endif
);

  // GF(2^4) multiply, polynomial basis mod x^4+x+1.
  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    logic [3:0] t;
    r = 4'h0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return r;
  endfunction

  // GF(2^4) inverse; 0 maps to 0, which carries the 0 -> 0 rule through the inverter.
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] r;
    r = 4'h0;
    for (int j = 1; j < 16; j++) begin
      if (gf4_mul(a, 4'(j)) == 4'h1) r = 4'(j);
    end
    return r;
  endfunction

  // Composite element {h,l} = h*y + l with y^2 = y + lam.
  function automatic logic [7:0] cmul(input logic [7:0] a, input logic [7:0] b,
                                      input logic [3:0] lam);
    logic [3:0] hh;
    logic [3:0] hi;
    logic [3:0] lo;
    hh = gf4_mul(a[7:4], b[7:4]);
    hi = hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]);
    lo = gf4_mul(hh, lam) ^ gf4_mul(a[3:0], b[3:0]);
    return {hi, lo};
  endfunction

  // Smallest lam making y^2+y+lam irreducible over GF(2^4) (no t with t^2+t = lam).
  function automatic logic [3:0] find_lambda();
    logic [3:0] res;
    logic       irr;
    logic       found;
    res   = 4'h0;
    found = 1'b0;
    for (int l = 1; l < 16; l++) begin
      irr = 1'b1;
      for (int t = 0; t < 16; t++) begin
        if ((gf4_mul(4'(t), 4'(t)) ^ 4'(t)) == 4'(l)) irr = 1'b0;
      end
      if (irr && !found) begin
        res   = 4'(l);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // A root of x^8+x^4+x^3+x+1 inside the composite field; x^i -> alpha^i is the basis change.
  function automatic logic [7:0] find_alpha(input logic [3:0] lam);
    logic [7:0] c;
    logic [7:0] c2;
    logic [7:0] c4;
    logic [7:0] ev;
    logic [7:0] res;
    logic       found;
    res   = 8'h00;
    found = 1'b0;
    for (int k = 2; k < 256; k++) begin
      c  = 8'(k);
      c2 = cmul(c, c, lam);
      c4 = cmul(c2, c2, lam);
      ev = cmul(c4, c4, lam) ^ c4 ^ cmul(c2, c, lam) ^ c ^ 8'h01;
      if (ev == 8'h00 && !found) begin
        res   = c;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Row r of the map matrix: bit i is bit r of alpha^i.
  function automatic logic [63:0] build_fwd_rows(input logic [7:0] alpha, input logic [3:0] lam);
    logic [63:0] rows;
    logic [7:0]  pw;
    rows = 64'h0;
    pw   = 8'h01;
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < 8; r++) rows[r*8+i] = pw[r];
      pw = cmul(pw, alpha, lam);
    end
    return rows;
  endfunction

  // Gauss-Jordan inverse of the 8x8 GF(2) map matrix.
  function automatic logic [63:0] build_inv_rows(input logic [63:0] fwd);
    logic [63:0] a;
    logic [63:0] v;
    logic [7:0]  tmp;
    logic        found;
    a = fwd;
    v = 64'h0;
    for (int r = 0; r < 8; r++) v[r*8+r] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      found = 1'b0;
      for (int p = c; p < 8; p++) begin
        if (!found && a[p*8+c]) begin
          found = 1'b1;
          tmp = a[p*8+:8]; a[p*8+:8] = a[c*8+:8]; a[c*8+:8] = tmp;
          tmp = v[p*8+:8]; v[p*8+:8] = v[c*8+:8]; v[c*8+:8] = tmp;
        end
      end
      for (int r = 0; r < 8; r++) begin
        if (r != c && a[r*8+c]) begin
          a[r*8+:8] = a[r*8+:8] ^ a[c*8+:8];
          v[r*8+:8] = v[r*8+:8] ^ v[c*8+:8];
        end
      end
    end
    return v;
  endfunction

  function automatic logic [7:0] mat_apply(input logic [63:0] rows, input logic [7:0] x);
    logic [7:0] y;
    for (int r = 0; r < 8; r++) y[r] = ^(rows[r*8+:8] & x);
    return y;
  endfunction

  localparam logic [3:0]  LAMBDA   = find_lambda();
  localparam logic [7:0]  ALPHA    = find_alpha(LAMBDA);
  localparam logic [63:0] FWD_ROWS = build_fwd_rows(ALPHA, LAMBDA);
  localparam logic [63:0] INV_ROWS = build_inv_rows(FWD_ROWS);

  logic       r_v1, r_v2, r_v3;
  logic [3:0] r_s1_a, r_s1_b, r_s1_c;
  logic [3:0] r_s2_a, r_s2_b, r_s2_cinv;
  logic [7:0] r_s3_data;
  logic       w_adv1, w_adv2, w_adv3;
  logic [7:0] w_b, w_z;
  logic [3:0] w_c, w_cinv, w_hi, w_lo;
  logic [7:0] w_out;

  assign w_adv3 = !r_v3 || out_ready;
  assign w_adv2 = !r_v2 || w_adv3;
  assign w_adv1 = !r_v1 || w_adv2;

  assign in_ready  = w_adv1;
  assign out_valid = r_v3;
  assign out_data  = r_s3_data;
  assign busy      = r_v1 | r_v2 | r_v3;

  // S1: inverse affine, basis change, norm C = A^2*lam + A*L + L^2 with A = high, B = A^L.
  assign w_b = {in_data[6:0], in_data[7]} ^ {in_data[4:0], in_data[7:5]}
             ^ {in_data[1:0], in_data[7:2]} ^ 8'h05;
  assign w_z = mat_apply(FWD_ROWS, w_b);
  assign w_c = gf4_mul(gf4_mul(w_z[7:4], w_z[7:4]), LAMBDA)
             ^ gf4_mul(w_z[7:4], w_z[3:0]) ^ gf4_mul(w_z[3:0], w_z[3:0]);

  // S2: invert the norm in GF(2^4).
  assign w_cinv = gf4_inv(r_s1_c);

  // S3: inverse = (A*C^-1) y + (B*C^-1), then back to the polynomial basis.
  assign w_hi  = gf4_mul(r_s2_a, r_s2_cinv);
  assign w_lo  = gf4_mul(r_s2_b, r_s2_cinv);
  assign w_out = mat_apply(INV_ROWS, {w_hi, w_lo});

`ifdef PPRM_INV_PARITY_EN
  logic r_s3_par;
  assign out_parity = r_s3_par;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      r_s1_a    <= 4'h0;
      r_s1_b    <= 4'h0;
      r_s1_c    <= 4'h0;
      r_s2_a    <= 4'h0;
      r_s2_b    <= 4'h0;
      r_s2_cinv <= 4'h0;
      r_s3_data <= 8'h00;
`ifdef PPRM_INV_PARITY_EN
      r_s3_par  <= 1'b0;
`endif
    end else begin
      if (w_adv3) begin
        r_v3      <= r_v2;
        r_s3_data <= w_out;
`ifdef PPRM_INV_PARITY_EN
        r_s3_par  <= ^w_out;
`endif
      end
      if (w_adv2) begin
        r_v2      <= r_v1;
        r_s2_a    <= r_s1_a;
        r_s2_b    <= r_s1_b;
        r_s2_cinv <= w_cinv;
      end
      if (w_adv1) begin
        r_v1   <= in_valid;
        r_s1_a <= w_z[7:4];
        r_s1_b <= w_z[7:4] ^ w_z[3:0];
        r_s1_c <= w_c;
      end
    end
  end

endmodule

// File: tb/tb_pprm_inv_sbox_pipe.sv
// tb/tb_pprm_inv_sbox_pipe.sv - self-checking bench for pprm_inv_sbox_pipe

module tb_pprm_inv_sbox_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
`ifdef PPRM_INV_PARITY_EN
  logic       out_parity;
`endif

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] vec_in  [5] = '{8'h7C, 8'hFF, 8'hED, 8'h63, 8'h00};
  logic [7:0] vec_out [5] = '{8'h01, 8'h7D, 8'h53, 8'h00, 8'h52};

  always #5 clk = ~clk;

  pprm_inv_sbox_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef PPRM_INV_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ t;
      t = t[7] ? ((t << 1) ^ 8'h1B) : (t << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int j = 1; j < 256; j++) begin
      if (gmul(a, 8'(j)) == 8'h01) r = 8'(j);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] inv_sbox_ref(input logic [7:0] x);
    return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL por_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL por_busy: got %b expected 0", busy); else n_pass++;
    rst = 1'b0;
    // fill the pipeline, then reset it
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = 8'(8'h11 * (c + 1));
      step();
    end
    in_valid = 1'b0;
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b expected 0", in_ready); else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_total++; if (out_data !== 8'h00) $display("FAIL rst_out_data: got %h expected 00", out_data); else n_pass++;
    // single byte latency
    in_valid = 1'b1; in_data = 8'h63; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    n_total++; if (lat !== 3) $display("FAIL single_latency: got %0d expected 3", lat); else n_pass++;
    n_total++; if (out_data !== 8'h00) $display("FAIL single_data: got %h expected 00", out_data); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL single_no_dup: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_streaming();
    logic [7:0] si [4] = '{8'h00, 8'h7C, 8'hFF, 8'hED};
    logic [7:0] so [4] = '{8'h52, 8'h01, 8'h7D, 8'h53};
    out_ready = 1'b1;
    for (int s = 0; s < 7; s++) begin
      in_valid = (s < 4);
      in_data  = (s < 4) ? si[s] : 8'h00;
      step();
      if (s < 2) begin
        n_total++; if (out_valid !== 1'b0) $display("FAIL stream_early_valid[%0d]: got %b expected 0", s, out_valid); else n_pass++;
      end else if (s >= 2 && s < 6) begin
        n_total++; if (out_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b expected 1", s, out_valid); else n_pass++;
        n_total++; if (out_data !== so[s-2]) $display("FAIL stream_data[%0d]: got %h expected %h", s, out_data, so[s-2]); else n_pass++;
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    int acc;
    int got;
    int gaps;
    int cyc;
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = vec_in[acc];
      #1;
      if (in_ready) acc++;
      step();
    end
    in_data = vec_in[acc < 5 ? acc : 4];
    #1;
    n_total++; if (acc !== 3) $display("FAIL bp_accepted: got %0d expected 3", acc); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", in_ready); else n_pass++;
    n_total++; if (out_data !== 8'h01) $display("FAIL bp_head: got %h expected 01", out_data); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b1 || out_data !== 8'h01) $display("FAIL bp_stable: got %b/%h expected 1/01", out_valid, out_data); else n_pass++;
    out_ready = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_full_passthru: got %b expected 1", in_ready); else n_pass++;
    got = 0; gaps = 0; cyc = 0;
    while (got < 5 && cyc < 20) begin
      in_valid = (acc < 5);
      in_data  = vec_in[acc < 5 ? acc : 4];
      #1;
      if (!out_valid) gaps++;
      if (out_valid && out_ready) begin
        n_total++; if (out_data !== vec_out[got]) $display("FAIL bp_order[%0d]: got %h expected %h", got, out_data, vec_out[got]); else n_pass++;
        got++;
      end
      if (in_valid && in_ready) acc++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    n_total++; if (got !== 5) $display("FAIL bp_count: got %0d expected 5", got); else n_pass++;
    n_total++; if (gaps !== 0) $display("FAIL bp_gaps: got %0d expected 0", gaps); else n_pass++;
  endtask

  task automatic test_exhaustive();
    int sent;
    int rcvd;
    int cyc;
    logic hold;
    logic [7:0] pd;
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 256 && cyc < 5000) begin
      in_valid  = (sent < 256) && ($urandom_range(0, 3) != 0);
      in_data   = 8'(sent);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      hold = out_valid && !out_ready;
      pd   = out_data;
      if (out_valid && out_ready) begin
        n_total++; if (out_data !== inv_sbox_ref(8'(rcvd))) $display("FAIL exh_inv[%0d]: got %h expected %h", rcvd, out_data, inv_sbox_ref(8'(rcvd))); else n_pass++;
        n_total++; if (sbox_ref(out_data) !== 8'(rcvd)) $display("FAIL exh_roundtrip[%0d]: got %h expected %h", rcvd, sbox_ref(out_data), 8'(rcvd)); else n_pass++;
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      step();
      if (hold) begin
        n_total++; if (out_valid !== 1'b1 || out_data !== pd) $display("FAIL exh_hold: got %b/%h expected 1/%h", out_valid, out_data, pd); else n_pass++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_total++; if (rcvd !== 256) $display("FAIL exh_count: got %0d expected 256", rcvd); else n_pass++;
  endtask

  task automatic test_async_reset();
    int seen;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(c);
      step();
    end
    in_valid = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b1 || busy !== 1'b1) $display("FAIL ar_full: got %b/%b expected 1/1", out_valid, busy); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL ar_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL ar_busy: got %b expected 0", busy); else n_pass++;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (out_valid) seen++;
    end
    n_total++; if (seen !== 0) $display("FAIL ar_stale: got %0d expected 0", seen); else n_pass++;
  endtask

`ifdef PPRM_INV_PARITY_EN
  task automatic test_parity();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hFF;
    step();
    in_data = 8'h7C;
    step();
    in_valid = 1'b0;
    step();
    n_total++; if (out_data !== 8'h7D || out_parity !== 1'b0) $display("FAIL par_ff: got %h/%b expected 7d/0", out_data, out_parity); else n_pass++;
    step();
    n_total++; if (out_data !== 8'h01 || out_parity !== 1'b1) $display("FAIL par_7c: got %h/%b expected 01/1", out_data, out_parity); else n_pass++;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_exhaustive();
    test_async_reset();
`ifdef PPRM_INV_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
